// File: rtl/axadd_pipe.sv
// axadd_pipe: two-stage valid/ready approximate adder with seven lower-part modes chosen per beat.
// Optional macro AXADD_ERRSTAT_EN builds exact-sum error statistics; without it stat_* read 0.
module axadd_pipe #(
    parameter int BIT_WIDTH = 8,
    parameter int KMAX      = 5,
    parameter int KW        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIT_WIDTH-1:0]    in_a,
    input  logic [BIT_WIDTH-1:0]    in_b,
    input  logic [2:0]              in_mode,
    input  logic [KW-1:0]           in_k,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIT_WIDTH:0]      out_sum,
    output logic                    out_exact,
    input  logic                    stat_clr,
    output logic [31:0]             stat_cnt,
    output logic [32+BIT_WIDTH-1:0] stat_abs_err
);
    localparam int SW = BIT_WIDTH + 1;
    localparam int AW = 32 + BIT_WIDTH;

    typedef enum logic [2:0] {
        MODE_EXACT  = 3'd0,
        MODE_COPY_A = 3'd1,
        MODE_COPY_B = 3'd2,
        MODE_LOA    = 3'd3,
        MODE_TRUNC0 = 3'd4,
        MODE_TRUNC1 = 3'd5,
        MODE_ETA1   = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    logic                 s1_valid_q;
    logic [BIT_WIDTH-1:0] s1_a_q, s1_b_q;
    mode_e                s1_mode_q;
    logic [KW-1:0]        s1_keff_q;
    logic                 s2_valid_q;
    logic [SW-1:0]        s2_sum_q;
    logic                 s2_exact_q;

    logic                 s1_load, s2_load;
    logic [KW-1:0]        keff_d;
    logic [SW-1:0]        sum_d, exact_sum;
    logic                 exact_d;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign keff_d   = (in_k > KW'(KMAX)) ? KW'(KMAX) : in_k;

`ifdef AXADD_ERRSTAT_EN
    logic [SW-1:0] s1_ref_q, s2_ref_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_EXACT;
            s1_keff_q  <= '0;
`ifdef AXADD_ERRSTAT_EN
            s1_ref_q   <= '0;
`endif
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_mode_q <= mode_e'(in_mode);
                s1_keff_q <= keff_d;
`ifdef AXADD_ERRSTAT_EN
                s1_ref_q  <= SW'(in_a) + SW'(in_b);
`endif
            end
        end
    end

    logic [SW-1:0]        ext_a, ext_b, mask, upper, lower;
    logic [BIT_WIDTH-1:0] p, g, eta;
    logic                 eta_s;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        ext_a = SW'(s1_a_q);
        ext_b = SW'(s1_b_q);
`ifdef AXADD_ERRSTAT_EN
        exact_sum = s1_ref_q;
`else
        exact_sum = ext_a + ext_b;
`endif
        mask  = (SW'(1) << s1_keff_q) - SW'(1);
        upper = ((ext_a >> s1_keff_q) + (ext_b >> s1_keff_q)) << s1_keff_q;
        p     = s1_a_q ^ s1_b_q;
        g     = s1_a_q & s1_b_q;
        eta   = '0;
        eta_s = 1'b0;
        for (int i = KMAX - 1; i >= 0; i--) begin
            if (i < int'(s1_keff_q)) begin
                eta_s  = (i == int'(s1_keff_q) - 1) ? p[i] : (eta_s | g[i]);
                eta[i] = eta_s | p[i];
            end
        end
        lower = '0;
        case (s1_mode_q)
            MODE_COPY_A: lower = ext_a;
            MODE_COPY_B: lower = ext_b;
            MODE_LOA:    lower = ext_a | ext_b;
            MODE_TRUNC1: lower = '1;
            MODE_ETA1:   lower = SW'(eta);
            default:     lower = '0;
        endcase
        exact_d = (s1_mode_q == MODE_EXACT) || (s1_mode_q == MODE_RSVD) || (s1_keff_q == '0);
        sum_d   = exact_d ? exact_sum : (upper | (lower & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_exact_q <= 1'b0;
`ifdef AXADD_ERRSTAT_EN
            s2_ref_q   <= '0;
`endif
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q   <= sum_d;
                s2_exact_q <= exact_d;
`ifdef AXADD_ERRSTAT_EN
                s2_ref_q   <= exact_sum;
`endif
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = s2_sum_q;
    assign out_exact = s2_exact_q;

`ifdef AXADD_ERRSTAT_EN
    logic [31:0]   cnt_q;
    logic [AW-1:0] abs_q;
    logic [SW-1:0] err;
    logic [AW:0]   abs_sum;

    assign err     = (s2_ref_q >= s2_sum_q) ? (s2_ref_q - s2_sum_q) : (s2_sum_q - s2_ref_q);
    assign abs_sum = {1'b0, abs_q} + (AW+1)'(err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            abs_q <= '0;
        end else if (stat_clr) begin
            cnt_q <= '0;
            abs_q <= '0;
        end else if (out_valid && out_ready && (err != '0)) begin
            cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 32'd1;
            abs_q <= abs_sum[AW] ? '1 : abs_sum[AW-1:0];
        end
    end

    assign stat_cnt     = cnt_q;
    assign stat_abs_err = abs_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
    assign stat_abs_err    = '0;
`endif
endmodule

// File: tb/tb_axadd_pipe.sv
// Scoreboard bench for axadd_pipe: directed mode sweep, K clamp, backpressure, mid-stream reset, stats.
module tb_axadd_pipe;
    localparam int BW   = 8;
    localparam int KMAX = 5;
    localparam int KW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready, out_exact, stat_clr;
    logic [BW-1:0]   in_a, in_b;
    logic [2:0]      in_mode;
    logic [KW-1:0]   in_k;
    logic [BW:0]     out_sum;
    logic [31:0]     stat_cnt;
    logic [32+BW-1:0] stat_abs_err;

    axadd_pipe #(.BIT_WIDTH(BW), .KMAX(KMAX), .KW(KW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_exact(out_exact),
        .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_abs_err(stat_abs_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW:0] sum;
        logic        exact;
        int          cyc;
        logic        lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        lat_en = 1'b0;
    logic [BW:0] drv_sum;
    logic        drv_exact;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_k(input logic [KW-1:0] k);
        return (int'(k) > KMAX) ? KMAX : int'(k);
    endfunction

    function automatic logic model_exact(input logic [2:0] m, input logic [KW-1:0] k);
        return (m == 3'd0) || (m == 3'd7) || (eff_k(k) == 0);
    endfunction

    // Reference written bit-by-bit; ETA-I uses the closed form of the suffix OR.
    function automatic logic [BW:0] model_sum(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic [2:0] m, input logic [KW-1:0] k);
        int          ke;
        logic [BW:0] r;
        logic [BW-1:0] p, g;
        logic        s;
        ke = eff_k(k);
        if (model_exact(m, k)) return {1'b0, a} + {1'b0, b};
        r = ({1'b0, a >> ke} + {1'b0, b >> ke}) << ke;
        p = a ^ b;
        g = a & b;
        for (int i = 0; i < ke; i++) begin
            case (m)
                3'd1: r[i] = a[i];
                3'd2: r[i] = b[i];
                3'd3: r[i] = a[i] | b[i];
                3'd4: r[i] = 1'b0;
                3'd5: r[i] = 1'b1;
                default: begin
                    s = p[ke-1];
                    for (int j = i; j < ke - 1; j++) s = s | g[j];
                    r[i] = s | p[i];
                end
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_out: observed sum %0h with empty scoreboard", out_sum);
                end
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_sum", out_sum, e.sum);
                    check("out_exact", out_exact, e.exact);
                    if (e.lat) check("latency", cyc - e.cyc, 2);
                end
            end
            if (in_valid && in_ready) sb_q.push_back('{drv_sum, drv_exact, cyc, lat_en});
        end
    end

    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [2:0] m,
                        input logic [KW-1:0] k, input logic [BW:0] es, input logic ee);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_k = k;
        drv_sum = es; drv_exact = ee;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_m(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [2:0] m,
                          input logic [KW-1:0] k);
        send(a, b, m, k, model_sum(a, b, m, k), model_exact(m, k));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW:0] sweep_exp [8];
        logic [BW:0] held;
        logic        saw_full;
        logic [31:0] exp_cnt;
        logic [32+BW-1:0] exp_abs;

        sweep_exp = '{9'h096, 9'h08A, 9'h08C, 9'h08E, 9'h080, 9'h08F, 9'h086, 9'h096};
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_k = '0;
        out_ready = 1'b1; stat_clr = 1'b0; drv_sum = '0; drv_exact = 1'b0;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_exact", out_exact, 0);
        check("rst_stat_cnt", stat_cnt, 0);
        check("rst_stat_abs", stat_abs_err, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        lat_en = 1'b1;
        for (int m = 0; m < 8; m++)
            send(8'h5A, 8'h3C, 3'(m), 4'd4, sweep_exp[m], (m == 0) || (m == 7));
        drain();

        // The LOA lower part does not carry into the upper part, so FF+01 at keff=5 stays 0x0FF.
        send(8'hFF, 8'h01, 3'd3, 4'd15, 9'h0FF, 1'b0);
        send(8'hFF, 8'h01, 3'd3, 4'd0, 9'h100, 1'b1);
        for (int i = 0; i < 10; i++)
            send_m(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        drain();
        lat_en = 1'b0;

        saw_full = 1'b0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_m(8'(8'h13 * i + 8'h07), 8'(8'h2F ^ (i * 7)), 3'd3, 4'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (!in_ready) saw_full = 1'b1;
                    check("stall_valid", out_valid, 1);
                    if (i > 0) check("stall_hold", out_sum, held);
                    held = out_sum;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("in_ready_dropped", saw_full, 1);
        drain();

        send_m(8'h21, 8'h42, 3'd6, 4'd3);
        send_m(8'h99, 8'h66, 3'd1, 4'd5);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sum", out_sum, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_post_rst", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("no_stale_out", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;

`ifdef AXADD_ERRSTAT_EN
        exp_cnt = 32'd1;
        exp_abs = 40'd8;
`else
        exp_cnt = 32'd0;
        exp_abs = 40'd0;
`endif
        send(8'h5A, 8'h3C, 3'd3, 4'd4, 9'h08E, 1'b0);
        send(8'h10, 8'h20, 3'd0, 4'd4, 9'h030, 1'b1);
        drain();
        @(negedge clk);
        check("stat_cnt", stat_cnt, exp_cnt);
        check("stat_abs_err", stat_abs_err, exp_abs);
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        check("stat_cnt_clr", stat_cnt, 0);
        check("stat_abs_clr", stat_abs_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
